// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-shared single-MAC FIR filter.
// A sample is accepted in IDLE and shifted into the delay line. The MAC
// state then walks the NTAPS taps one per cycle. OUT holds the saturated,
// rescaled result until the consumer takes it. Coefficients can only be
// rewritten in IDLE. Any rejected write raises coef_err for one cycle.
module fir_mac_sequencer #(
  parameter  int NTAPS = 8,
  parameter  int SHIFT = 15,
  localparam int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_wdata,
  output logic          coef_err,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic signed [15:0] x_r [NTAPS];
  logic signed [15:0] c_r [NTAPS];
  logic signed [39:0] acc_r;
  logic [AW-1:0]      idx_r;
  logic [15:0]        out_data_r;
  logic               coef_err_r;

  logic               accept_s;
  logic               last_s;
  logic               coef_ok_s;
  logic signed [31:0] prod_s;
  logic signed [39:0] prod_ext_s;
  logic signed [39:0] sum_s;
  logic signed [39:0] shifted_s;

  // Clamp a wide signed value into the 16-bit signed output range.
  function automatic logic [15:0] sat16(input logic signed [39:0] v);
    logic [15:0] r;
    if (v > 40'sd32767) begin
      r = 16'h7FFF;
    end else if (v < -40'sd32768) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = (state_r == OUT);
  assign out_data  = out_data_r;
  assign coef_err  = coef_err_r;

  // Handshake decode, MAC arithmetic and coefficient-write qualification.
  always_comb begin
    accept_s   = in_valid && (state_r == IDLE);
    last_s     = (idx_r == AW'(NTAPS - 1));
    coef_ok_s  = coef_we && (state_r == IDLE) && (32'(coef_addr) < NTAPS);
    prod_s     = x_r[idx_r] * c_r[idx_r];
    prod_ext_s = {{8{prod_s[31]}}, prod_s};
    sum_s      = acc_r + prod_ext_s;
    shifted_s  = sum_s >>> SHIFT;
  end

  // State register: reset or flush always lands in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = MAC;
          end else begin
            state_s = IDLE;
          end
        end
        MAC: begin
          if (last_s) begin
            state_s = OUT;
          end else begin
            state_s = MAC;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = OUT;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Delay line, coefficients, accumulator, tap index, result and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_r[i] <= 16'sd0;
        c_r[i] <= 16'sd0;
      end
      acc_r      <= 40'sd0;
      idx_r      <= '0;
      out_data_r <= 16'd0;
      coef_err_r <= 1'b0;
    end else begin
      // A write dropped because of flush is not reported as an error.
      coef_err_r <= coef_we && !flush && !coef_ok_s;
      if (flush) begin
        for (int i = 0; i < NTAPS; i++) begin
          x_r[i] <= 16'sd0;
        end
        acc_r <= 40'sd0;
        idx_r <= '0;
      end else begin
        if (coef_ok_s) begin
          c_r[coef_addr] <= coef_wdata;
        end
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              x_r[0] <= in_data;
              for (int i = 1; i < NTAPS; i++) begin
                x_r[i] <= x_r[i-1];
              end
              acc_r <= 40'sd0;
              idx_r <= '0;
            end
          end
          MAC: begin
            acc_r <= sum_s;
            if (last_s) begin
              idx_r      <= '0;
              out_data_r <= sat16(shifted_s);
            end else begin
              idx_r <= idx_r + AW'(1);
            end
          end
          OUT: begin
            acc_r <= acc_r;
          end
          default: begin
            acc_r <= 40'sd0;
            idx_r <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: a directed vector table plus
// hand-written sequences for reset, latency, backpressure, coefficient guard,
// saturation, flush and throughput. A second, 6-tap instance covers
// out-of-range coefficient addresses. These addresses cannot be encoded on
// the 3-bit address of the 8-tap instance.
module tb_fir_mac_sequencer;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        coef_err;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_in_data;
  logic        s_coef_we;
  logic [2:0]  s_coef_addr;
  logic [15:0] s_coef_wdata;
  logic        s_coef_err;
  logic        s_flush;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_out_data;
  logic        s_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int c0;
    int c1;
    int prev;
    int cur;
    int exp;
  } vec_t;

  vec_t tbl [8];

  fir_mac_sequencer #(.NTAPS(NT), .SHIFT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  fir_mac_sequencer #(.NTAPS(6), .SHIFT(15)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .coef_we(s_coef_we), .coef_addr(s_coef_addr),
    .coef_wdata(s_coef_wdata), .coef_err(s_coef_err), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .busy(s_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sout();
    return int'($signed(out_data));
  endfunction

  task automatic write_coef(input int a, input int d);
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = 16'(d);
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic accept(input int s);
    in_data  = 16'(s);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("out_valid_wait", int'(out_valid), 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int lat;
    int first;
    int second;
    bit seen;

    tbl[0] = '{16384,      0,      0,   1000,   500};
    tbl[1] = '{32767,      0,      0,  32767, 32766};
    tbl[2] = '{-16384,     0,      0,   1000,  -500};
    tbl[3] = '{16384,      0,      0,     -3,    -2};
    tbl[4] = '{-32768, -32768, -32768, -32768, 32767};
    tbl[5] = '{16384,  16384,    100,    200,   150};
    tbl[6] = '{8192,   -8192,      7,      0,    -2};
    tbl[7] = '{32767,  32767, -32768,  32767,    -1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; coef_we = 1'b0;
    coef_addr = 3'd0; coef_wdata = 16'd0; flush = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = 16'd0; s_coef_we = 1'b0; s_coef_addr = 3'd0;
    s_coef_wdata = 16'd0; s_flush = 1'b0; s_out_ready = 1'b0;

    // Reset: three cycles low, then release.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", sout(), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_coef_err", int'(coef_err), 0);

    // Impulse response and exact latency.
    write_coef(0, 16384);
    accept(1000);
    check("mac_busy", int'(busy), 1);
    check("mac_in_ready", int'(in_ready), 0);
    wait_out(lat);
    check("impulse_latency", lat, NT);
    check("impulse_out", sout(), 500);
    drain();
    check("idle_after_drain", int'(in_ready), 1);
    accept(0);
    wait_out(lat);
    check("impulse_zero", sout(), 0);
    drain();

    // Backpressure: output held, inputs ignored while stalled.
    accept(200);
    wait_out(lat);
    check("bp_out", sout(), 100);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 16'd777;
      tick();
      check("bp_hold_data", sout(), 100);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    drain();
    check("bp_release_idle", int'(in_ready), 1);
    check("bp_release_valid", int'(out_valid), 0);
    write_coef(1, 16384);
    accept(0);
    wait_out(lat);
    check("bp_no_dup_sample", sout(), 100);

    // Coefficient guard: writes during OUT and MAC are rejected.
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd32767;
    tick();
    coef_we = 1'b0;
    check("guard_out_err", int'(coef_err), 1);
    drain();
    check("guard_err_single", int'(coef_err), 0);
    accept(40);
    tick();
    write_coef(0, 32767);
    check("guard_mac_err", int'(coef_err), 1);
    tick();
    check("guard_mac_err_drop", int'(coef_err), 0);
    wait_out(lat);
    check("guard_result", sout(), 20);
    drain();

    // Coefficient write at the same edge as accept takes effect.
    do_flush();
    write_coef(1, 0);
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd8192;
    accept(1000);
    coef_we = 1'b0;
    check("same_edge_no_err", int'(coef_err), 0);
    wait_out(lat);
    check("same_edge_coef", sout(), 250);
    drain();

    // Saturation at both rails.
    do_flush();
    for (int i = 0; i < NT; i++) write_coef(i, 32767);
    for (int i = 0; i < NT; i++) begin
      accept(32767);
      wait_out(lat);
      if (i == 0) check("sat_first", sout(), 32766);
      drain();
    end
    check("sat_pos", sout(), 32767);
    for (int i = 0; i < NT; i++) begin
      accept(-32768);
      wait_out(lat);
      drain();
    end
    check("sat_neg", sout(), -32768);

    // Vector table: two-tap responses after a flush.
    for (int v = 0; v < 8; v++) begin
      do_flush();
      write_coef(0, tbl[v].c0);
      write_coef(1, tbl[v].c1);
      for (int i = 2; i < NT; i++) write_coef(i, 0);
      accept(tbl[v].prev);
      wait_out(lat);
      drain();
      accept(tbl[v].cur);
      wait_out(lat);
      check($sformatf("vec%0d_out", v), sout(), tbl[v].exp);
      drain();
    end

    // Flush mid-MAC: no output, delay line cleared.
    accept(500);
    repeat (3) tick();
    do_flush();
    check("flush_idle", int'(in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_out", int'(seen), 0);
    accept(0);
    wait_out(lat);
    check("flush_cleared_x", sout(), 0);
    drain();

    // Flush wins over a simultaneous accept.
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd1000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_over_accept", int'(busy), 0);

    // Reset at MAC idx 3 discards the computation.
    accept(100);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_idle", int'(in_ready), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_out", int'(seen), 0);
    check("rst_cleared_out_data", sout(), 0);
    write_coef(1, 32767);
    accept(100);
    wait_out(lat);
    check("rst_cleared_x", sout(), 0);
    drain();

    // Throughput with continuous input and output handshakes.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd0;
    first = -1; second = -1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (out_valid) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("thru_first", first, NT + 1);
    check("thru_period", second - first, NT + 2);
    wait_out(lat);
    drain();

    // Six-tap instance: out-of-range address is rejected.
    s_coef_we = 1'b1; s_coef_addr = 3'd0; s_coef_wdata = 16'd16384;
    tick();
    check("range_ok_no_err", int'(s_coef_err), 0);
    s_coef_addr = 3'd6; s_coef_wdata = 16'd32767;
    tick();
    s_coef_we = 1'b0;
    check("range_err", int'(s_coef_err), 1);
    tick();
    check("range_err_drop", int'(s_coef_err), 0);
    s_in_valid = 1'b1; s_in_data = 16'd1000;
    tick();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("range_latency", lat, 6);
    check("range_result", int'($signed(s_out_data)), 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
